// File: rtl/smp8_prog_loader.sv
// Framed byte-stream loader for the SMP8 instruction memory; holds the core in reset until a good image lands.
// Optional build macro SMP8_LOADER_ZERO_FILL_EN pads addresses N..MAX_WORDS-1 with NOP after a good image.
module smp8_prog_loader #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

`ifdef SMP8_LOADER_ZERO_FILL_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR, S_FILL} state_t;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(MAX_WORDS - 1);
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
`endif

  localparam logic [DATA_W-1:0] MAX_N = DATA_W'(MAX_WORDS);
  localparam logic [DATA_W-1:0] ONE_N = DATA_W'(1);

  state_t            state;
  logic [DATA_W-1:0] len;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W-1:0] addr;
  logic              xfer;

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  function automatic logic len_ok(input logic [DATA_W-1:0] n);
    return (n != '0) && (n <= MAX_N);
  endfunction

  assign in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      len        <= '0;
      sum        <= '0;
      addr       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LEN;
            busy  <= 1'b1;
          end
        end
        S_LEN: begin
          if (xfer) begin
            len <= in_data;
            if (len_ok(in_data)) begin
              state      <= S_DATA;
              sum        <= '0;
              addr       <= '0;
              word_count <= '0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          // Write is registered: the byte accepted on this edge appears on the imem port next cycle.
          if (xfer) begin
            sum        <= csum_add(sum, in_data);
            mem_we     <= 1'b1;
            mem_addr   <= addr;
            mem_wd     <= in_data;
            addr       <= addr + 1'b1;
            word_count <= word_count + 1'b1;
            if (DATA_W'(word_count) + ONE_N == len) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (in_data == sum) begin
`ifdef SMP8_LOADER_ZERO_FILL_EN
              if (len == MAX_N) begin
                state     <= S_DONE;
                done      <= 1'b1;
                cpu_reset <= 1'b0;
                busy      <= 1'b0;
              end else begin
                // First pad write is issued on entry so FILL shows mem_we in every cycle.
                state    <= S_FILL;
                mem_we   <= 1'b1;
                mem_addr <= addr;
                mem_wd   <= '0;
                addr     <= addr + 1'b1;
              end
`else
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              busy      <= 1'b0;
`endif
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
`ifdef SMP8_LOADER_ZERO_FILL_EN
        S_FILL: begin
          if (mem_addr == LAST_A) begin
            state     <= S_DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= addr;
            mem_wd   <= '0;
            addr     <= addr + 1'b1;
          end
        end
`endif
        S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_LEN;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smp8_prog_loader.sv
// Directed bench for smp8_prog_loader: framing, checksum, length bounds, stalls, restart and mid-load reset.
module tb_smp8_prog_loader;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
`ifdef SMP8_LOADER_ZERO_FILL_EN
  localparam int FILL_EN = 1;
`else
  localparam int FILL_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, mem_we, cpu_reset, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int log_n = 0;
  logic [ADDR_W-1:0] wa [256];
  logic [DATA_W-1:0] wd [256];
  int                wc [256];

  smp8_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(64)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1 && log_n < 256) begin
      wa[log_n] = mem_addr;
      wd[log_n] = mem_wd;
      wc[log_n] = cyc;
      log_n = log_n + 1;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] b);
    logic took;
    took = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !took; n++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
    end
    if (!took) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(done || err)) begin
      checks++; errors++;
      $display("FAIL wait_end_timeout: done=%b err=%b after %0d cycles", done, err, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    log_n = 0;
    checks++;
    if (cpu_reset !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cpu_reset=%b in_ready=%b busy=%b done=%b err=%b expected 1 0 0 0 0",
               cpu_reset, in_ready, busy, done, err);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_wd !== 8'd0 || word_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_data: we=%b addr=%0d wd=%h wc=%0d expected all 0", mem_we, mem_addr, mem_wd, word_count);
    end
    in_valid = 1'b1; in_data = 8'h03;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (log_n !== 0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL idle_quiet: writes=%0d busy=%b cpu_reset=%b expected 0 0 1", log_n, busy, cpu_reset);
    end
  endtask

  task automatic test_good(input string tag);
    logic [7:0] pay [3] = '{8'h11, 8'h84, 8'hA0};
    int exp_n;
    exp_n = FILL_EN ? 64 : 3;
    log_n = 0;
    pulse_start();
    send(8'h03);
    checks++;
    if (busy !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: busy=%b cpu_reset=%b expected 1 1", tag, busy, cpu_reset);
    end
    for (int i = 0; i < 3; i++) send(pay[i]);
    send(8'h35);
    in_valid = 1'b0;
`ifndef SMP8_LOADER_ZERO_FILL_EN
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_latency: done=%b cpu_reset=%b expected 1 0", tag, done, cpu_reset);
    end
`endif
    wait_end();
    checks++;
    if (log_n !== exp_n) begin
      errors++;
      $display("FAIL %s_write_count: got %0d expected %0d", tag, log_n, exp_n);
    end
    for (int i = 0; i < exp_n && i < log_n; i++) begin
      checks++;
      if (wa[i] !== 6'(i) || wd[i] !== (i < 3 ? pay[i] : 8'h00) || wc[i] !== wc[0] + i) begin
        errors++;
        $display("FAIL %s_write%0d: addr=%0d data=%h cyc_off=%0d expected addr=%0d data=%h cyc_off=%0d",
                 tag, i, wa[i], wd[i], wc[i] - wc[0], i, (i < 3 ? pay[i] : 8'h00), i);
      end
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || cpu_reset !== 1'b0 || busy !== 1'b0 || word_count !== 7'd3) begin
      errors++;
      $display("FAIL %s_final: done=%b err=%b cpu_reset=%b busy=%b wc=%0d expected 1 0 0 0 3",
               tag, done, err, cpu_reset, busy, word_count);
    end
  endtask

  task automatic test_bad_csum();
    log_n = 0;
    pulse_start();
    checks++;
    if (done !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: done=%b cpu_reset=%b busy=%b expected 0 1 1", done, cpu_reset, busy);
    end
    send(8'h03); send(8'h11); send(8'h84); send(8'hA0); send(8'h36);
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1 || log_n !== 3) begin
      errors++;
      $display("FAIL bad_csum: err=%b done=%b cpu_reset=%b writes=%0d expected 1 0 1 3", err, done, cpu_reset, log_n);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b cpu_reset=%b expected 1 1", err, cpu_reset);
    end
    test_good("recover");
  endtask

  task automatic test_len_bounds();
    log_n = 0;
    pulse_start();
    send(8'h00);
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || log_n !== 0) begin
      errors++;
      $display("FAIL len_zero: err=%b done=%b busy=%b writes=%0d expected 1 0 0 0", err, done, busy, log_n);
    end
    pulse_start();
    send(8'h41);
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || log_n !== 0) begin
      errors++;
      $display("FAIL len_65: err=%b in_ready=%b writes=%0d expected 1 0 0", err, in_ready, log_n);
    end
    pulse_start();
    send(8'h40);
    for (int i = 0; i < 64; i++) send(8'h01);
    send(8'h40);
    in_valid = 1'b0;
    wait_end();
    checks++;
    if (log_n !== 64 || done !== 1'b1 || err !== 1'b0 || word_count !== 7'd64 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL len_64: writes=%0d done=%b err=%b wc=%0d cpu_reset=%b expected 64 1 0 64 0",
               log_n, done, err, word_count, cpu_reset);
    end
    for (int i = 0; i < 64 && i < log_n; i++) begin
      checks++;
      if (wa[i] !== 6'(i) || wd[i] !== 8'h01 || wc[i] !== wc[0] + i) begin
        errors++;
        $display("FAIL len_64_write%0d: addr=%0d data=%h cyc_off=%0d expected %0d 01 %0d",
                 i, wa[i], wd[i], wc[i] - wc[0], i, i);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] strm [5] = '{8'h03, 8'h11, 8'h84, 8'hA0, 8'h35};
    logic [7:0] pay  [3] = '{8'h11, 8'h84, 8'hA0};
    int exp_n;
    exp_n = FILL_EN ? 64 : 3;
    log_n = 0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b0;
      start = (i == 2);
      @(posedge clk); #1;
      start = 1'b0;
      send(strm[i]);
    end
    in_valid = 1'b0;
    wait_end();
    checks++;
    if (log_n !== exp_n || done !== 1'b1 || err !== 1'b0 || word_count !== 7'd3) begin
      errors++;
      $display("FAIL stall_final: writes=%0d done=%b err=%b wc=%0d expected %0d 1 0 3",
               log_n, done, err, word_count, exp_n);
    end
    for (int i = 0; i < 3 && i < log_n; i++) begin
      checks++;
      if (wa[i] !== 6'(i) || wd[i] !== pay[i] || wc[i] !== wc[0] + 2 * i) begin
        errors++;
        $display("FAIL stall_write%0d: addr=%0d data=%h cyc_off=%0d expected %0d %h %0d",
                 i, wa[i], wd[i], wc[i] - wc[0], i, pay[i], 2 * i);
      end
    end
  endtask

  task automatic test_mid_reset();
    log_n = 0;
    pulse_start();
    send(8'h03); send(8'h11); send(8'h84);
    in_valid = 1'b0;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: cpu_reset=%b busy=%b done=%b err=%b in_ready=%b expected 1 0 0 0 0",
               cpu_reset, busy, done, err, in_ready);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_wd !== 8'd0 || word_count !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset_data: we=%b addr=%0d wd=%h wc=%0d expected all 0", mem_we, mem_addr, mem_wd, word_count);
    end
    checks++;
    if (log_n !== 2 || wa[1] !== 6'd1 || wd[1] !== 8'h84) begin
      errors++;
      $display("FAIL mid_reset_writes: writes=%0d last_addr=%0d last_data=%h expected 2 1 84", log_n, wa[1], wd[1]);
    end
  endtask

  initial begin
    test_reset();
    test_good("good");
    test_bad_csum();
    test_len_bounds();
    test_stall();
    test_mid_reset();
    test_good("after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/smp8_prog_loader.md
Name: smp8_prog_loader

Overview:
- Byte-stream program loader for the SMP8 accumulator processor. It is the writer for the instruction memory, which the core only reads.
- Accepts a framed image of the form: length byte, N payload bytes, checksum byte.
- Writes the payload into imem at addresses 0..N-1 and holds the core in reset until a valid image is loaded.
- Sits between a host byte source (UART RX or bench) and the imem write port, and drives the core's reset input.

Parameters:
ADDR_W, 6, imem address width (matches the 64-entry imem)
DATA_W, 8, instruction/byte width
MAX_WORDS, 64, maximum payload length accepted; must be <= 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a new load
in_data  input  DATA_W  stream byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  imem write enable, one cycle per write
mem_addr  output  ADDR_W  imem write address
mem_wd  output  DATA_W  imem write data
cpu_reset  output  1  active-high reset to the core
busy  output  1  load in progress
done  output  1  last load succeeded; sticky until next start or reset
err  output  1  last load failed; sticky until next start or reset
word_count  output  ADDR_W+1  payload bytes written so far

Behaviour:
- Reset values: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wd=0, cpu_reset=1, busy=0, done=0, err=0, word_count=0; internal length, sum and address counters all 0.
- Handshake: a byte transfers on a rising edge when in_valid && in_ready. in_ready is combinational from state only: 1 in LEN, DATA and CSUM, otherwise 0. It never depends on in_valid.
- IDLE:
  - start -> LEN; cpu_reset stays 1.
- LEN:
  - On transfer, latch N = in_data.
  - N==0 or N>MAX_WORDS -> ERR.
  - Otherwise -> DATA; clear sum, address and word_count.
- DATA:
  - Each transfer adds in_data to sum, modulo 2**DATA_W.
  - Registered write: mem_we=1, mem_addr=address, mem_wd=in_data in the cycle after the transfer, for exactly one cycle.
  - address and word_count increment by 1 on each transfer.
  - After the Nth transfer -> CSUM.
  - Back-to-back transfers give back-to-back writes, one per cycle, with no bubbles.
- CSUM:
  - On transfer, if in_data == sum -> DONE (or FILL, see optional feature); else -> ERR.
  - No memory write occurs in CSUM.
- DONE:
  - done=1, cpu_reset=0 from the first cycle in DONE. The core therefore leaves reset the cycle after the checksum byte is accepted, once the final mem_we pulse has retired.
- ERR:
  - err=1, cpu_reset=1.
  - Memory already written is not rolled back.
- Restart: start in DONE or ERR -> LEN. In that same edge, clear done and err and re-assert cpu_reset=1.
- start in LEN, DATA, CSUM or FILL is ignored.
- busy=1 in LEN, DATA, CSUM and FILL.
- in_valid with in_ready=0 has no effect; the byte is not consumed.
- A reset asserted mid-load aborts the load at the next edge to the full reset values, including cpu_reset=1. Partially written imem contents are left as they are.
- Simultaneous start and reset: reset wins.
- Address arithmetic: mem_addr never exceeds MAX_WORDS-1. N==MAX_WORDS writes addresses 0..MAX_WORDS-1 with no wrap.

Optional Feature:
- Macro: SMP8_LOADER_ZERO_FILL_EN.
- Defined: after a matching checksum, go to FILL instead of DONE.
  - FILL writes 0x00 (NOP) to addresses N..MAX_WORDS-1, one write per cycle, mem_we=1 each cycle, in_ready=0, cpu_reset=1.
  - After writing MAX_WORDS-1 -> DONE.
  - If N==MAX_WORDS, FILL is skipped and the loader goes directly to DONE.
  - word_count is not incremented by fill writes.
- Not defined: the FILL state does not exist; addresses N and above are left untouched.

Test Plan:
- Reset then idle: hold reset 3 cycles, release -> cpu_reset=1, in_ready=0, done=0, err=0, mem_we never asserted while idle.
- Good load: start; stream 0x03, 0x11, 0x84, 0xA0, 0x35 with in_valid held high -> mem_we pulses at addr 0/1/2 with data 0x11/0x84/0xA0 on consecutive cycles; word_count=3; done=1, cpu_reset=0.
- Bad checksum: same stream but checksum 0x36 -> err=1, cpu_reset stays 1, done=0; restart with start plus the good stream -> done=1, err=0.
- Length bounds: length byte 0x00 -> err=1 with no mem_we; length 0x41 (65) -> err=1; length 0x40 with 64 bytes 0x01 and checksum 0x40 -> writes addr 0..63, done=1.
- Stalls and mid-load reset: toggle in_valid every other cycle -> same writes as the good-load case, spaced out. Assert reset after the 2nd payload byte -> all outputs return to reset values and cpu_reset=1.
- Zero fill (macro defined): good 3-byte load -> 61 consecutive mem_we pulses with data 0x00 at addresses 3..63, then done=1, cpu_reset=0, word_count=3.
